// File: rtl/trap_pkg.sv
// Shared types and constants for the M-mode trap/interrupt sequencer.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE,
        ST_REDIR,
        ST_SLEEP,
        ST_MRET
    } state_e;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Pipeline/CSR-side signal bundle of the trap sequencer.
interface csr_trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            irq_ext;
    logic            irq_tmr;
    logic            mstatus_mie;
    logic            mie_meie;
    logic            mie_mtie;
    logic            ex_valid;
    logic            ex_is_wfi;
    logic            ex_is_mret;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] mepc_q;
    logic            mem_busy;

    logic            stall_pipe;
    logic            flush_pipe;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            csr_trap_we;
    logic [XLEN-1:0] csr_mepc_wdata;
    logic [XLEN-1:0] csr_mcause_wdata;
    logic            csr_mret_we;
    logic [31:0]     trap_count;

    modport master (
        input  irq_ext, irq_tmr, mstatus_mie, mie_meie, mie_mtie,
        input  ex_valid, ex_is_wfi, ex_is_mret, ex_pc, mepc_q, mem_busy,
        output stall_pipe, flush_pipe, pc_redirect, pc_target,
        output csr_trap_we, csr_mepc_wdata, csr_mcause_wdata,
        output csr_mret_we, trap_count
    );

    modport slave (
        output irq_ext, irq_tmr, mstatus_mie, mie_meie, mie_mtie,
        output ex_valid, ex_is_wfi, ex_is_mret, ex_pc, mepc_q, mem_busy,
        input  stall_pipe, flush_pipe, pc_redirect, pc_target,
        input  csr_trap_we, csr_mepc_wdata, csr_mcause_wdata,
        input  csr_mret_we, trap_count
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Interrupt pending/enable qualification and cause priority encoder.
module irq_prio_enc
    import trap_pkg::*;
(
    input  logic        irq_ext,
    input  logic        irq_tmr,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    output logic        pend_raw,
    output logic        take,
    output logic [31:0] cause
);

    logic ext_p;
    logic tmr_p;

    assign ext_p    = irq_ext & mie_meie;
    assign tmr_p    = irq_tmr & mie_mtie;
    assign pend_raw = ext_p | tmr_p;
    assign take     = pend_raw & mstatus_mie;
    // External outranks timer when both are pending.
    assign cause    = ext_p ? MCAUSE_MEI : MCAUSE_MTI;

endmodule

// File: rtl/csr_trap_sequencer.sv
// M-mode trap/interrupt sequencer: trap entry, MRET, WFI sleep, drain.
// Optional taken-trap counter enabled by macro TRAP_COUNT_EN.
module csr_trap_sequencer
    import trap_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] MTVEC_ADDR = 32'h0001_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csr_trap_sequencer_if.master bus
);

    logic        pend_raw;
    logic        take;
    logic [31:0] cause;

    irq_prio_enc u_prio (
        .irq_ext     (bus.irq_ext),
        .irq_tmr     (bus.irq_tmr),
        .mstatus_mie (bus.mstatus_mie),
        .mie_meie    (bus.mie_meie),
        .mie_mtie    (bus.mie_mtie),
        .pend_raw    (pend_raw),
        .take        (take),
        .cause       (cause)
    );

    state_e          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [31:0]     cause_q, cause_d;
    logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;
    logic [XLEN-1:0] redir_tgt;

    logic            stall_q, stall_d;
    logic            flush_q, flush_d;
    logic            redir_q, redir_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            trap_we_q, trap_we_d;
    logic [XLEN-1:0] mepc_w_q, mepc_w_d;
    logic [XLEN-1:0] mcause_w_q, mcause_w_d;
    logic            mret_we_q, mret_we_d;

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        wfi_pc_d  = wfi_pc_q;
        redir_tgt = MTVEC_ADDR;

        unique case (state_q)
            ST_IDLE: begin
                if (take & bus.ex_valid & !bus.mem_busy) begin
                    state_d = ST_SAVE;
                    epc_d   = bus.ex_pc;
                    cause_d = cause;
                end else if (take & bus.mem_busy) begin
                    state_d = ST_DRAIN;
                end else if (bus.ex_valid & bus.ex_is_mret) begin
                    state_d = ST_MRET;
                end else if (bus.ex_valid & bus.ex_is_wfi & !pend_raw) begin
                    state_d  = ST_SLEEP;
                    wfi_pc_d = bus.ex_pc;
                end
            end
            ST_DRAIN: begin
                // A withdrawn interrupt or a bubble in EX drops back to IDLE.
                if (!bus.mem_busy) begin
                    if (take & bus.ex_valid) begin
                        state_d = ST_SAVE;
                        epc_d   = bus.ex_pc;
                        cause_d = cause;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SAVE: begin
                state_d   = ST_REDIR;
                redir_tgt = MTVEC_ADDR;
            end
            ST_SLEEP: begin
                if (pend_raw) begin
                    if (take) begin
                        state_d = ST_SAVE;
                        epc_d   = pc_plus4(wfi_pc_q);
                        cause_d = cause;
                    end else begin
                        state_d   = ST_REDIR;
                        redir_tgt = pc_plus4(wfi_pc_q);
                    end
                end
            end
            ST_REDIR: state_d = ST_IDLE;
            ST_MRET:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_comb begin
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        redir_d    = 1'b0;
        target_d   = '0;
        trap_we_d  = 1'b0;
        mepc_w_d   = '0;
        mcause_w_d = '0;
        mret_we_d  = 1'b0;

        unique case (state_d)
            ST_DRAIN, ST_SLEEP: stall_d = 1'b1;
            ST_SAVE: begin
                stall_d    = 1'b1;
                trap_we_d  = 1'b1;
                mepc_w_d   = epc_d;
                mcause_w_d = cause_d;
            end
            ST_REDIR: begin
                redir_d  = 1'b1;
                flush_d  = 1'b1;
                target_d = redir_tgt;
            end
            ST_MRET: begin
                mret_we_d = 1'b1;
                redir_d   = 1'b1;
                flush_d   = 1'b1;
                target_d  = bus.mepc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            epc_q      <= '0;
            cause_q    <= '0;
            wfi_pc_q   <= '0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            target_q   <= '0;
            trap_we_q  <= 1'b0;
            mepc_w_q   <= '0;
            mcause_w_q <= '0;
            mret_we_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            wfi_pc_q   <= wfi_pc_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            redir_q    <= redir_d;
            target_q   <= target_d;
            trap_we_q  <= trap_we_d;
            mepc_w_q   <= mepc_w_d;
            mcause_w_q <= mcause_w_d;
            mret_we_q  <= mret_we_d;
        end
    end

    assign bus.stall_pipe       = stall_q;
    assign bus.flush_pipe       = flush_q;
    assign bus.pc_redirect      = redir_q;
    assign bus.pc_target        = target_q;
    assign bus.csr_trap_we      = trap_we_q;
    assign bus.csr_mepc_wdata   = mepc_w_q;
    assign bus.csr_mcause_wdata = mcause_w_q;
    assign bus.csr_mret_we      = mret_we_q;

`ifdef TRAP_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (trap_we_q) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.trap_count = cnt_q;
`else
    assign bus.trap_count = '0;
`endif

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Scoreboard bench for csr_trap_sequencer: directed trap/MRET/WFI/drain/reset.
module tb_csr_trap_sequencer;

    localparam logic [31:0] MTVEC = 32'h0001_0000;
    localparam logic [31:0] C_MEI = 32'h8000_000B;
    localparam logic [31:0] C_MTI = 32'h8000_0007;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    csr_trap_sequencer_if #(.XLEN(32)) bus ();

    csr_trap_sequencer #(
        .XLEN       (32),
        .MTVEC_ADDR (32'h0001_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // kind: 0 trap entry, 1 redirect, 2 mret
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] cause;
        int          run;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  exp_tc = 0;
    int  run = 0;
    int  last_run = 0;
    ev_t me;
    int  kind_act;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] addr,
                        input logic [31:0] cause, input int r);
        ev_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.addr  = addr;
        e.cause = cause;
        e.run   = r;
        q.push_back(e);
        if (kind == 0) exp_tc++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.irq_ext     = 1'b0;
        bus.irq_tmr     = 1'b0;
        bus.mstatus_mie = 1'b0;
        bus.mie_meie    = 1'b0;
        bus.mie_mtie    = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_is_wfi   = 1'b0;
        bus.ex_is_mret  = 1'b0;
        bus.ex_pc       = '0;
        bus.mepc_q      = '0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, bus.stall_pipe}, 0);
        chk({tag, "_flush"}, {31'd0, bus.flush_pipe}, 0);
        chk({tag, "_redir"}, {31'd0, bus.pc_redirect}, 0);
        chk({tag, "_target"}, bus.pc_target, 0);
        chk({tag, "_trap_we"}, {31'd0, bus.csr_trap_we}, 0);
        chk({tag, "_mepc_w"}, bus.csr_mepc_wdata, 0);
        chk({tag, "_mcause_w"}, bus.csr_mcause_wdata, 0);
        chk({tag, "_mret_we"}, {31'd0, bus.csr_mret_we}, 0);
        chk({tag, "_trap_count"}, bus.trap_count, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits an event.
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (bus.stall_pipe) begin
                run++;
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (bus.csr_trap_we | bus.pc_redirect | bus.csr_mret_we) begin
                if (q.size() == 0) begin
                    chk("unexpected_event",
                        {29'd0, bus.csr_trap_we, bus.pc_redirect,
                         bus.csr_mret_we}, 0);
                end else begin
                    me = q.pop_front();
                    kind_act = bus.csr_trap_we ? 0 : (bus.csr_mret_we ? 2 : 1);
                    chk("ev_kind", kind_act, me.kind);
                    chk("ev_cycle", cyc, me.cyc);
                    if (me.kind == 0) begin
                        chk("trap_mepc", bus.csr_mepc_wdata, me.addr);
                        chk("trap_mcause", bus.csr_mcause_wdata, me.cause);
                        chk("trap_stall", {31'd0, bus.stall_pipe}, 1);
                        chk("trap_no_redir", {31'd0, bus.pc_redirect}, 0);
                    end else begin
                        chk("redir_target", bus.pc_target, me.addr);
                        chk("redir_flush", {31'd0, bus.flush_pipe}, 1);
                        chk("redir_stall", {31'd0, bus.stall_pipe}, 0);
                        chk("stall_run", last_run, me.run);
                        last_run = 0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected end");
        $fatal(1);
    end

    initial begin
        int n;
        idle_in();
        rst_n = 1'b0;
        #12;
        chk_zero("reset");
        rst_n = 1'b1;
        step(2);

        // Basic external interrupt trap
        n = cyc;
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h100;
        push(0, n + 1, 32'h100, C_MEI, 0);
        push(1, n + 2, MTVEC, 0, 1);
        step(1);
        idle_in();
        step(3);

        // MRET without interrupt
        n = cyc;
        bus.mepc_q     = 32'h3C;
        bus.ex_valid   = 1'b1;
        bus.ex_is_mret = 1'b1;
        bus.ex_pc      = 32'h400;
        push(2, n + 1, 32'h3C, 0, 0);
        step(1);
        idle_in();
        step(3);

        // MRET with simultaneous interrupt: trap wins
        n = cyc;
        bus.mepc_q      = 32'h3C;
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_is_mret  = 1'b1;
        bus.ex_pc       = 32'h500;
        push(0, n + 1, 32'h500, C_MEI, 0);
        push(1, n + 2, MTVEC, 0, 1);
        step(1);
        idle_in();
        step(3);

        // Both pending: external first, timer after MIE restored
        n = cyc;
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.mie_mtie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.irq_tmr     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h600;
        push(0, n + 1, 32'h600, C_MEI, 0);
        push(1, n + 2, MTVEC, 0, 1);
        step(1);
        bus.mstatus_mie = 1'b0;
        step(1);
        n = cyc;
        bus.irq_ext     = 1'b0;
        bus.mstatus_mie = 1'b1;
        bus.ex_pc       = 32'h604;
        push(0, n + 2, 32'h604, C_MTI, 0);
        push(1, n + 3, MTVEC, 0, 1);
        step(2);
        idle_in();
        step(3);

        // WFI with MIE=0: wake without trap, resume at wfi_pc+4
        n = cyc;
        bus.mie_mtie  = 1'b1;
        bus.ex_valid  = 1'b1;
        bus.ex_is_wfi = 1'b1;
        bus.ex_pc     = 32'h200;
        step(1);
        bus.ex_valid  = 1'b0;
        bus.ex_is_wfi = 1'b0;
        step(9);
        bus.irq_tmr = 1'b1;
        push(1, n + 11, 32'h204, 0, 10);
        step(1);
        idle_in();
        step(3);

        // WFI at top of memory with MIE=1: trap, mepc wraps to 0
        n = cyc;
        bus.mstatus_mie = 1'b1;
        bus.mie_mtie    = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_is_wfi   = 1'b1;
        bus.ex_pc       = 32'hFFFF_FFFC;
        step(1);
        bus.ex_valid  = 1'b0;
        bus.ex_is_wfi = 1'b0;
        step(2);
        bus.irq_tmr = 1'b1;
        push(0, n + 4, 32'h0, C_MTI, 0);
        push(1, n + 5, MTVEC, 0, 4);
        step(1);
        idle_in();
        step(3);

        // Interrupt while memory busy for 5 cycles
        n = cyc;
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h300;
        bus.mem_busy    = 1'b1;
        step(5);
        bus.mem_busy = 1'b0;
        bus.ex_pc    = 32'h304;
        push(0, n + 6, 32'h304, C_MEI, 0);
        push(1, n + 7, MTVEC, 0, 6);
        step(1);
        idle_in();
        step(3);

        // Interrupt withdrawn during drain is dropped
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h380;
        bus.mem_busy    = 1'b1;
        step(2);
        bus.irq_ext = 1'b0;
        step(2);
        bus.mem_busy = 1'b0;
        step(3);
        idle_in();
        step(2);

        // Bubble in EX: wait until a real instruction arrives
        n = cyc;
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b0;
        bus.ex_pc       = 32'h700;
        step(3);
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h704;
        push(0, n + 4, 32'h704, C_MEI, 0);
        push(1, n + 5, MTVEC, 0, 1);
        step(1);
        idle_in();
        step(3);

        // Reset asserted during SAVE
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h800;
        step(1);
        chk("save_before_reset", {31'd0, bus.csr_trap_we}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_in_save");
        idle_in();
        exp_tc = 0;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("tc_after_reset", bus.trap_count, 0);

        // FSM back in IDLE: a fresh trap has single-cycle latency
        n = cyc;
        bus.mstatus_mie = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.irq_ext     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h900;
        push(0, n + 1, 32'h900, C_MEI, 0);
        push(1, n + 2, MTVEC, 0, 1);
        step(1);
        idle_in();
        step(4);

        chk("queue_empty", q.size(), 0);
`ifdef TRAP_COUNT_EN
        chk("trap_count", bus.trap_count, exp_tc);
`else
        chk("trap_count", bus.trap_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Machine-mode trap/interrupt sequencer for the 5-stage core. Sits beside the EX stage and CSR file.
- Decides when a pending external or timer interrupt is taken, and which instruction in EX it lands on.
- Drives CSR trap-entry and MRET update strobes, pipeline stall/flush, and PC redirect.
- Also handles WFI sleep/wake, and holds off traps while a DRAM/ROM access is in flight.

Parameters:
MTVEC_ADDR, 32'h0001_0000, fixed trap vector (direct mode) loaded into PC on trap entry
XLEN, 32, data/address width

Ports:
clk  input  1  core clock
rst_n  input  1  reset; asynchronous, active-low
irq_ext  input  1  external interrupt level (MEIP)
irq_tmr  input  1  timer interrupt level (MTIP)
mstatus_mie  input  1  mstatus.MIE, already forwarded to the current EX view
mie_meie  input  1  mie.MEIE
mie_mtie  input  1  mie.MTIE
ex_valid  input  1  EX holds a real (non-bubble) instruction
ex_is_wfi  input  1  EX instruction is WFI
ex_is_mret  input  1  EX instruction is MRET
ex_pc  input  XLEN  PC of the EX instruction
mepc_q  input  XLEN  current mepc from CSR file
mem_busy  input  1  DRAM/ROM access outstanding; pipeline cannot be flushed
stall_pipe  output  1  freeze IF..EX
flush_pipe  output  1  kill IF/ID/EX contents
pc_redirect  output  1  load pc_target into PC
pc_target  output  XLEN  redirect address
csr_trap_we  output  1  1-cycle strobe; CSR file performs MPIE<=MIE, MIE<=0, MPP<=2'b11, and writes mepc/mcause
csr_mepc_wdata  output  XLEN  value for mepc
csr_mcause_wdata  output  XLEN  value for mcause
csr_mret_we  output  1  1-cycle strobe; CSR file performs MIE<=MPIE, MPIE<=1
trap_count  output  32  taken-trap counter (see optional feature)

Behaviour:
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE.
- pend_raw = (irq_ext & mie_meie) | (irq_tmr & mie_mtie).
- take = pend_raw & mstatus_mie.
- Cause priority: external over timer.
  - External: mcause = 32'h8000_000B.
  - Timer: mcause = 32'h8000_0007.
- FSM states: IDLE, DRAIN, SAVE, REDIR, SLEEP, MRET.
- IDLE, evaluated in priority order:
  1. take & ex_valid & !mem_busy → SAVE. Capture epc = ex_pc; the EX instruction is not retired.
  2. take & mem_busy → DRAIN.
  3. ex_valid & ex_is_mret → MRET.
  4. ex_valid & ex_is_wfi & !pend_raw → SLEEP.
  5. Otherwise stay in IDLE.
- DRAIN: stall_pipe=1.
  - Leave when !mem_busy. Re-evaluate take: if take → SAVE with epc=ex_pc, else → IDLE.
  - An interrupt withdrawn during DRAIN is dropped.
- SAVE (1 cycle): stall_pipe=1, csr_trap_we=1, csr_mepc_wdata=epc, csr_mcause_wdata=latched cause → REDIR.
- REDIR (1 cycle): pc_redirect=1, pc_target=MTVEC_ADDR, flush_pipe=1 → IDLE.
- MRET (1 cycle): csr_mret_we=1, pc_redirect=1, pc_target=mepc_q, flush_pipe=1 → IDLE.
- SLEEP: stall_pipe=1 until pend_raw.
  - If take → SAVE with epc = wfi_pc+4.
  - Else → REDIR-like one-cycle resume: pc_redirect=1, pc_target=wfi_pc+4, flush=1 → IDLE.
- Latency: interrupt in IDLE at cycle N with EX valid gives csr_trap_we at N+1 and pc_redirect at N+2.
- Interrupt raised in the same cycle as MRET or WFI in EX: the trap wins. mepc = that instruction's PC, so MRET/WFI re-executes after the handler.
- ex_valid=0 (bubble) with take in IDLE: wait in IDLE; never save a bubble PC.
- Interrupt levels are not latched. Deassertion before SAVE cancels the trap, except once in SAVE, where the cause is already latched.
- PC+4 wraps modulo 2^32.
- rst_n assertion in any state forces IDLE and zeroes outputs asynchronously.

Optional Feature:
- Macro TRAP_COUNT_EN.
- Defined: trap_count increments by 1 on each csr_trap_we cycle, wraps at 2^32, resets to 0.
- Undefined: the counter register is not synthesised and trap_count is tied to 0.

Decomposition:
- Package trap_pkg holds:
  - State enum.
  - MCAUSE_MEI=32'h8000_000B and MCAUSE_MTI=32'h8000_0007.
  - CSR address constants: MSTATUS 12'h300, MIE 12'h304, MEPC 12'h341, MCAUSE 12'h342.
- One sub-module, irq_prio_enc: combinational; produces pend_raw, take and cause from the interrupt/enable inputs.

Test Plan:
1. MIE=1, MEIE=1, irq_ext=1 at N with ex_pc=0x100, ex_valid=1 → N+1: csr_trap_we=1, mepc_wdata=0x100, mcause=0x8000000B; N+2: pc_redirect=1, pc_target=0x10000, flush=1.
2. irq_ext and irq_tmr both asserted with both enables set → mcause=0x8000000B; timer trap taken only after irq_ext drops and MIE is restored.
3. WFI at 0x200, MIE=0, MTIE=1, irq_tmr asserted 10 cycles later → stall held 10 cycles; then resume redirect to 0x204, csr_trap_we stays 0.
4. Interrupt while mem_busy=1 for 5 cycles → DRAIN with stall for 5 cycles; SAVE follows with mepc=ex_pc current at mem_busy fall.
5. MRET in EX with mepc_q=0x3C and no interrupt → csr_mret_we=1, pc_target=0x3C, flush=1 for exactly one cycle. Repeat with irq_ext simultaneous → trap taken, mepc_wdata = the MRET's PC.
6. rst_n pulled low during SAVE → all outputs 0 immediately; FSM in IDLE after release; trap_count=0 with TRAP_COUNT_EN.
